// File: rtl/nibble_serial_adder_ctrl_if.sv
// Handshake/operand bundle for nibble_serial_adder_ctrl.
// sub_in exists only when NIBBLE_ADDER_SUB_EN is defined.
interface nibble_serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum_out;
  logic             cout_out;
  logic             busy;
`ifdef NIBBLE_ADDER_SUB_EN
  logic             sub_in;

  modport master (
    output in_valid, a_in, b_in, cin_in, sub_in, out_ready,
    input  in_ready, out_valid, sum_out, cout_out, busy
  );

  modport slave (
    input  in_valid, a_in, b_in, cin_in, sub_in, out_ready,
    output in_ready, out_valid, sum_out, cout_out, busy
  );
`else
  modport master (
    output in_valid, a_in, b_in, cin_in, out_ready,
    input  in_ready, out_valid, sum_out, cout_out, busy
  );

  modport slave (
    input  in_valid, a_in, b_in, cin_in, out_ready,
    output in_ready, out_valid, sum_out, cout_out, busy
  );
`endif
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit adder built from one 4-bit ripple slice, one nibble per clock, LSB first.
// Optional subtract mode (sub_in on the interface) enabled by defining NIBBLE_ADDER_SUB_EN.

module ripple_carry_4_bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);
  logic [4:0] c;

  always_comb begin
    c     = '0;
    sum_o = '0;
    c[0]  = cin_i;
    for (int unsigned i = 0; i < 4; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    cout_o = c[4];
  end
endmodule

module nibble_serial_adder_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  nibble_serial_adder_ctrl_if.slave bus
);
  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [3:0]       slice_sum;
  logic             slice_cout;
  logic [WIDTH+3:0] acc_cat;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  ripple_carry_4_bit u_slice (
    .a_i    (a_q[3:0]),
    .b_i    (b_q[3:0]),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  // New nibble enters at the top; after NIBBLES passes the LSB nibble has reached bit 0.
  assign acc_cat = {slice_sum, acc_q};
  assign acc_d   = acc_cat[WIDTH+3:4];

`ifdef NIBBLE_ADDER_SUB_EN
  // a - b computed as a + ~b + 1; carry out doubles as the no-borrow flag.
  always_comb begin
    b_load = bus.b_in;
    c_load = bus.cin_in;
    if (bus.sub_in) begin
      b_load = ~bus.b_in;
      c_load = 1'b1;
    end
  end
`else
  always_comb begin
    b_load = bus.b_in;
    c_load = bus.cin_in;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a_in;
            b_q        <= b_load;
            carry_q    <= c_load;
            cnt_q      <= '0;
            acc_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          a_q     <= a_q >> 4;
          b_q     <= b_q >> 4;
          acc_q   <= acc_d;
          carry_q <= slice_cout;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NIBBLES - 1)) begin
            state_q     <= DONE;
            sum_q       <= acc_d;
            cout_q      <= slice_cout;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum_out   = sum_q;
  assign bus.cout_out  = cout_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Randomized self-checking bench for nibble_serial_adder_ctrl (WIDTH=16).
module tb_nibble_serial_adder_ctrl;
  localparam int NIB = 4;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   cyc;

  nibble_serial_adder_ctrl_if #(.WIDTH(16)) bus ();

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact 17-bit result of a + b + cin, or a - b as a + ~b + 1.
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    logic [15:0] nb;
    nb = ~b;
    if (sub) return {1'b0, a} + {1'b0, nb} + 17'd1;
    return {1'b0, a} + {1'b0, b} + {16'd0, cin};
  endfunction

  task automatic set_sub(input logic s);
`ifdef NIBBLE_ADDER_SUB_EN
    bus.sub_in = s;
`else
    if (s) $display("note: subtract requested without NIBBLE_ADDER_SUB_EN");
`endif
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic sub, input string tag);
    logic [16:0] exp;
    int lat;
    exp = model(a, b, cin, sub);
    bus.a_in = a; bus.b_in = b; bus.cin_in = cin; set_sub(sub);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready: in_ready=%b want 1", tag, bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a_in = 16'($urandom); bus.b_in = 16'($urandom); bus.cin_in = 1'($urandom);
    set_sub(1'b0);
    checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s run: busy=%b in_ready=%b out_valid=%b want 1 0 0",
               tag, bus.busy, bus.in_ready, bus.out_valid);
    end
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat != NIB) begin
      errors++; $display("FAIL %s latency: got %0d cycles want %0d", tag, lat, NIB);
    end
    checks++;
    if ({bus.cout_out, bus.sum_out} !== exp) begin
      errors++;
      $display("FAIL %s result: cout=%b sum=%h want cout=%b sum=%h",
               tag, bus.cout_out, bus.sum_out, exp[16], exp[15:0]);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s release: out_valid=%b in_ready=%b busy=%b want 0 1 0",
               tag, bus.out_valid, bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a_in = '0; bus.b_in = '0; bus.cin_in = 1'b0; set_sub(1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.sum_out !== 16'h0 || bus.cout_out !== 1'b0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b sum=%h cout=%b want 1 0 0 0000 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.sum_out, bus.cout_out);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    do_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, "basic");
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "wrap");
    do_op(16'h0000, 16'h0000, 1'b1, 1'b0, "cin_only");
  endtask

  task automatic test_random();
    logic s;
    for (int i = 0; i < 16; i++) begin
`ifdef NIBBLE_ADDER_SUB_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      do_op(16'($urandom), 16'($urandom), 1'($urandom), s, "random");
    end
  endtask

  task automatic test_backpressure();
    logic [16:0] exp;
    int lat;
    exp = model(16'h4321, 16'h1111, 1'b1, 1'b0);
    bus.a_in = 16'h4321; bus.b_in = 16'h1111; bus.cin_in = 1'b1; set_sub(1'b0);
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      bus.a_in = 16'($urandom); bus.b_in = 16'($urandom);
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat != NIB) begin
      errors++; $display("FAIL bp latency: got %0d cycles want %0d", lat, NIB);
    end
    for (int i = 0; i < 10; i++) begin
      bus.a_in = 16'($urandom); bus.b_in = 16'($urandom); bus.cin_in = 1'($urandom);
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          {bus.cout_out, bus.sum_out} !== exp) begin
        errors++;
        $display("FAIL bp hold: out_valid=%b in_ready=%b cout=%b sum=%h want 1 0 %b %h",
                 bus.out_valid, bus.in_ready, bus.cout_out, bus.sum_out, exp[16], exp[15:0]);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL bp release: out_valid=%b in_ready=%b busy=%b want 0 1 0",
               bus.out_valid, bus.in_ready, bus.busy);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp no_second_accept: busy=%b in_ready=%b want 0 1",
                         bus.busy, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid_op();
    bus.a_in = 16'hABCD; bus.b_in = 16'h1234; bus.cin_in = 1'b0; set_sub(1'b0);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.sum_out !== 16'h0 || bus.cout_out !== 1'b0) begin
      errors++;
      $display("FAIL midreset: in_ready=%b out_valid=%b busy=%b sum=%h cout=%b want 1 0 0 0000 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.sum_out, bus.cout_out);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 2) rst_n = 1'b1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL midreset idle: out_valid=%b busy=%b want 0 0",
                           bus.out_valid, bus.busy);
      end
    end
    do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [15:0] oa [3];
    logic [15:0] ob [3];
    logic [16:0] expq [$];
    logic [16:0] exp;
    int idx;
    int last_out;
    logic prev_ready;
    oa[0] = 16'h8000; ob[0] = 16'h8000;
    oa[1] = 16'h7FFF; ob[1] = 16'h0001;
    oa[2] = 16'hAAAA; ob[2] = 16'h5555;
    idx = 0; last_out = -1;
    bus.out_ready = 1'b1; bus.cin_in = 1'b0; set_sub(1'b0);
    bus.a_in = oa[0]; bus.b_in = ob[0]; bus.in_valid = 1'b1;
    for (int c = 0; c < 60 && (idx < 3 || expq.size() > 0); c++) begin
      prev_ready = bus.in_ready;
      @(posedge clk); #1;
      if (prev_ready === 1'b1 && idx < 3) begin
        expq.push_back(model(oa[idx], ob[idx], 1'b0, 1'b0));
        idx++;
        if (idx < 3) begin
          bus.a_in = oa[idx]; bus.b_in = ob[idx];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (bus.out_valid === 1'b1) begin
        exp = (expq.size() > 0) ? expq.pop_front() : 17'h1FFFF;
        checks++;
        if ({bus.cout_out, bus.sum_out} !== exp) begin
          errors++;
          $display("FAIL b2b result: cout=%b sum=%h want cout=%b sum=%h",
                   bus.cout_out, bus.sum_out, exp[16], exp[15:0]);
        end
        if (last_out >= 0) begin
          checks++;
          if (cyc - last_out != NIB + 2) begin
            errors++; $display("FAIL b2b spacing: got %0d cycles want %0d",
                               cyc - last_out, NIB + 2);
          end
        end
        last_out = cyc;
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (idx != 3 || expq.size() != 0) begin
      errors++; $display("FAIL b2b timeout: accepted=%0d pending=%0d want 3 0",
                         idx, expq.size());
    end
    @(posedge clk); #1;
  endtask

`ifdef NIBBLE_ADDER_SUB_EN
  task automatic test_sub();
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, "sub_borrow");
    do_op(16'h0007, 16'h0005, 1'b0, 1'b1, "sub_noborrow");
    do_op(16'h0007, 16'h0005, 1'b1, 1'b0, "sub_off");
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
`ifdef NIBBLE_ADDER_SUB_EN
    test_sub();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
